// File: rtl/aibnd_txseq_ctl.sv
// AIB TX pad sequencer: pad-reset release, driver-strength ramp up/down,
// and data-path select for a single transmit pad.
module aibnd_txseq_ctl #(
  parameter int unsigned PADRST_CYC = 8
) (
  input  logic       clk,
  input  logic       irstb,
  input  logic       tx_req,
  input  logic [1:0] cfg_ndrv,
  input  logic [1:0] cfg_pdrv,
  input  logic [3:0] cfg_step_dly,
  input  logic       cfg_async,
  input  logic       cfg_weakpu,
  output logic       ipadrstb,
  output logic       itx_en,
  output logic [1:0] indrv,
  output logic [1:0] ipdrv,
  output logic       idataselb,
  output logic       test_weakpu,
  output logic       tx_ready,
  output logic       busy
);

  localparam int unsigned DRV_W  = 2;
  localparam int unsigned DLY_W  = 4;
  localparam int unsigned PCNT_W = 8;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PADRST_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PADRST  = 3'd1,
    S_RAMP    = 3'd2,
    S_ON      = 3'd3,
    S_RAMP_DN = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic              r_armed;
  logic [PCNT_W-1:0] r_pcnt;
  logic [DLY_W-1:0]  r_tmr;
  logic [DRV_W-1:0]  r_ndrv;
  logic [DRV_W-1:0]  r_pdrv;
  logic [DRV_W-1:0]  w_ndrv_tgt;
  logic [DRV_W-1:0]  w_pdrv_tgt;
  logic              w_at_tgt;
  logic              w_codes_zero;
  logic              w_ramping;
  logic              w_ramping_nxt;
  logic              w_step;

  logic r_padrstb, r_txen, r_dataselb, r_weakpu, r_ready, r_busy;
  logic w_padrstb, w_txen, w_dataselb, w_weakpu, w_ready, w_busy;

  // One code step toward the target, saturating at the target.
  function automatic logic [DRV_W-1:0] f_step(input logic [DRV_W-1:0] cur,
                                               input logic [DRV_W-1:0] tgt);
    logic [DRV_W-1:0] res;
    res = cur;
    if (cur < tgt)      res = cur + DRV_W'(1);
    else if (cur > tgt) res = cur - DRV_W'(1);
    return res;
  endfunction

  assign w_at_tgt      = (r_ndrv == cfg_ndrv) && (r_pdrv == cfg_pdrv);
  assign w_codes_zero  = (r_ndrv == '0) && (r_pdrv == '0);
  assign w_ndrv_tgt    = (r_state == S_RAMP_DN) ? '0 : cfg_ndrv;
  assign w_pdrv_tgt    = (r_state == S_RAMP_DN) ? '0 : cfg_pdrv;
  assign w_ramping     = (r_state == S_RAMP) || (r_state == S_RAMP_DN);
  assign w_ramping_nxt = (w_nxt == S_RAMP) || (w_nxt == S_RAMP_DN);
  assign w_step        = w_ramping && (w_nxt == r_state) && (r_tmr == '0);

  // State register; r_armed swallows the reset-release edge.
  always_ff @(posedge clk or negedge irstb) begin
    if (!irstb) begin
      r_state <= S_OFF;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_armed <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    if (r_armed) begin
      case (r_state)
        S_OFF:     if (tx_req) w_nxt = S_PADRST;
        S_PADRST: begin
          if (!tx_req)                 w_nxt = S_OFF;
          else if (r_pcnt == PCNT_LAST) w_nxt = S_RAMP;
        end
        S_RAMP: begin
          if (!tx_req)       w_nxt = S_RAMP_DN;
          else if (w_at_tgt) w_nxt = S_ON;
        end
        S_ON: begin
          if (!tx_req)        w_nxt = S_RAMP_DN;
          else if (!w_at_tgt) w_nxt = S_RAMP;
        end
        S_RAMP_DN: if (w_codes_zero) w_nxt = S_OFF;
        default:   w_nxt = S_OFF;
      endcase
    end
  end

  // Output values for the state being entered, registered below.
  always_comb begin
    w_padrstb  = 1'b0;
    w_txen     = 1'b0;
    w_dataselb = 1'b1;
    w_weakpu   = 1'b0;
    w_ready    = 1'b0;
    w_busy     = 1'b0;
    case (w_nxt)
      S_PADRST: begin
        w_padrstb = 1'b1;
        w_weakpu  = cfg_weakpu;
        w_busy    = 1'b1;
      end
      S_RAMP, S_RAMP_DN: begin
        w_padrstb = 1'b1;
        w_txen    = 1'b1;
        w_busy    = 1'b1;
      end
      S_ON: begin
        w_padrstb  = 1'b1;
        w_txen     = 1'b1;
        w_ready    = 1'b1;
        w_dataselb = ~cfg_async;
      end
      default: ;
    endcase
  end

  // Pad-reset hold counter, step timer and driver codes.
  always_ff @(posedge clk or negedge irstb) begin
    if (!irstb) begin
      r_pcnt <= '0;
      r_tmr  <= '0;
      r_ndrv <= '0;
      r_pdrv <= '0;
    end else begin
      r_pcnt <= ((r_state == S_PADRST) && (w_nxt == S_PADRST)) ? r_pcnt + PCNT_W'(1) : '0;
      if (w_nxt != r_state)
        r_tmr <= w_ramping_nxt ? cfg_step_dly : '0;
      else if (w_ramping)
        r_tmr <= (r_tmr == '0) ? cfg_step_dly : r_tmr - DLY_W'(1);
      if (w_step) begin
        r_ndrv <= f_step(r_ndrv, w_ndrv_tgt);
        r_pdrv <= f_step(r_pdrv, w_pdrv_tgt);
      end
    end
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge irstb) begin
    if (!irstb) begin
      r_padrstb  <= 1'b0;
      r_txen     <= 1'b0;
      r_dataselb <= 1'b1;
      r_weakpu   <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_padrstb  <= w_padrstb;
      r_txen     <= w_txen;
      r_dataselb <= w_dataselb;
      r_weakpu   <= w_weakpu;
      r_ready    <= w_ready;
      r_busy     <= w_busy;
    end
  end

  assign ipadrstb    = r_padrstb;
  assign itx_en      = r_txen;
  assign indrv       = r_ndrv;
  assign ipdrv       = r_pdrv;
  assign idataselb   = r_dataselb;
  assign test_weakpu = r_weakpu;
  assign tx_ready    = r_ready;
  assign busy        = r_busy;

endmodule

// File: doc/aibnd_txseq_ctl.md
AIBND_TXSEQ_CTL -- requirements
Module: aibnd_txseq_ctl

Interface
REQ-001 Parameter PADRST_CYC, default 8, pad-reset release hold time in clk cycles (legal 1..255).
REQ-002 Port clk  input  1  controller clock; all state changes on the rising edge.
REQ-003 Port irstb  input  1  reset, asynchronous, active-low.
REQ-004 Port tx_req  input  1  level request to bring the TX pad up (1) or down (0).
REQ-005 Port cfg_ndrv  input  2  target N-driver strength code.
REQ-006 Port cfg_pdrv  input  2  target P-driver strength code.
REQ-007 Port cfg_step_dly  input  4  cycles between drive steps, minus one.
REQ-008 Port cfg_async  input  1  1 selects the async data path when ON.
REQ-009 Port cfg_weakpu  input  1  weak pull-up request, honoured only while the pad is out of reset and TX is off.
REQ-010 Port ipadrstb  output  1  pad reset to TX datapath, active-low.
REQ-011 Port itx_en  output  1  TX driver enable.
REQ-012 Port indrv  output  2  current N-driver code.
REQ-013 Port ipdrv  output  2  current P-driver code.
REQ-014 Port idataselb  output  1  1 selects the clocked DDR path, 0 selects the async path.
REQ-015 Port test_weakpu  output  1  weak pull-up enable.
REQ-016 Port tx_ready  output  1  pad is driving at the target strength.
REQ-017 Port busy  output  1  sequence in progress (state not OFF or ON).

Function
REQ-018 FSM states SHALL be OFF, PADRST, RAMP, ON and RAMP_DN; all outputs SHALL be registered.
REQ-019 OFF: ipadrstb=0, itx_en=0, indrv=ipdrv=0, idataselb=1, test_weakpu=0, tx_ready=0; tx_req=1 SHALL move to PADRST.
REQ-020 PADRST: ipadrstb=1, itx_en=0, test_weakpu=cfg_weakpu; after exactly PADRST_CYC cycles in state, SHALL move to RAMP.
REQ-021 PADRST with tx_req=0 SHALL return to OFF on the next edge, abandoning the count.
REQ-022 RAMP: itx_en=1, test_weakpu=0; step timer SHALL load cfg_step_dly on entry and after each step; a step fires when the timer is 0.
REQ-023 On each step, indrv SHALL move by 1 toward cfg_ndrv and ipdrv by 1 toward cfg_pdrv, independently; a code already equal to its target holds; no wrap.
REQ-024 RAMP SHALL move to ON on the edge after both codes equal their targets; zero targets complete at the first step.
REQ-025 ON: tx_ready=1, idataselb=~cfg_async; a change of cfg_ndrv or cfg_pdrv SHALL re-enter RAMP with tx_ready=0 and idataselb=1.
REQ-026 tx_req=0 in RAMP or ON SHALL move to RAMP_DN on the next edge, with tx_ready=0 and idataselb=1.
REQ-027 RAMP_DN: itx_en=1; codes SHALL step toward 0 at the REQ-022 rate; once both are 0, the next edge SHALL go to OFF, deasserting itx_en and ipadrstb together.
REQ-028 tx_req=1 during RAMP_DN SHALL be ignored until OFF is reached; OFF then re-enters PADRST on the following edge.
REQ-029 cfg inputs SHALL be sampled every cycle; changes during RAMP retarget on the next step.

Reset
REQ-030 irstb=0 SHALL immediately force state OFF, all counters to 0, and outputs to their OFF values, regardless of clk.
REQ-031 Reset release SHALL take effect on the first rising clk edge with irstb=1; no sequence step occurs on the release edge itself.

Verification
REQ-032 PADRST_CYC=8, cfg_ndrv=3, cfg_pdrv=2, cfg_step_dly=0, tx_req=1 -> ipadrstb=1 for 8 cycles; indrv 1,2,3 and ipdrv 1,2,2 on consecutive cycles; tx_ready=1 one cycle later.
REQ-033 Reach ON with step_dly=3, then set tx_req=0 -> codes decrement every 4 cycles to 0, then itx_en=0 and ipadrstb=0 on the same edge, busy=0.
REQ-034 tx_req pulse of 3 cycles (PADRST_CYC=8) -> ipadrstb returns to 0 without itx_en ever asserting.
REQ-035 In ON at 3/3, set cfg_ndrv=1 -> tx_ready=0, indrv 2,1 while ipdrv holds 3, then tx_ready=1.
REQ-036 Assert irstb=0 mid-RAMP between clk edges -> all outputs at OFF values immediately; after release with tx_req=1, the full PADRST count restarts.
REQ-037 cfg_async=1 in ON -> idataselb=0; drop tx_req -> idataselb=1 on the next edge.
